gpio_debounce: RTL and testbench



---
 rtl/gpio_debounce.sv | 119 +++++++++++
 tb/tb_gpio_debounce.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce.sv
// gpio_debounce: per-pin pad synchroniser, shared tick prescaler and
// stability filter feeding the GPIO core's gpio_i. Accepted transitions
// raise change_o for one cycle; pending transitions that are abandoned
// raise glitch_o for one cycle.
module gpio_debounce #(
  parameter int PDATA_SIZE   = 8,
  parameter int CNT_SIZE     = 8,
  parameter int PRE_SIZE     = 16,
  parameter int INPUT_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [PRE_SIZE-1:0]   prescale_i,
  input  logic [CNT_SIZE-1:0]   threshold_i,
  input  logic [PDATA_SIZE-1:0] bypass_i,
  input  logic [PDATA_SIZE-1:0] pad_i,
  output logic [PDATA_SIZE-1:0] deb_o,
  output logic [PDATA_SIZE-1:0] change_o,
  output logic [PDATA_SIZE-1:0] glitch_o
);

  localparam logic [PRE_SIZE-1:0] PCNT_ONE = PRE_SIZE'(1);
  localparam logic [CNT_SIZE-1:0] CNT_ONE  = CNT_SIZE'(1);

  logic [PDATA_SIZE-1:0] sync_reg [INPUT_STAGES];
  logic [PDATA_SIZE-1:0] sync_s;
  logic [PRE_SIZE-1:0]   pcnt_reg;
  logic [PRE_SIZE-1:0]   pcnt_next;
  logic                  tick;

  // Synchroniser chain: stage 0 samples the asynchronous pads.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < INPUT_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
    end else begin
      sync_reg[0] <= pad_i;
      for (int i = 1; i < INPUT_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign sync_s = sync_reg[INPUT_STAGES-1];

  // Shared tick: the >= compare lets a lowered prescale take effect at once.
  always_comb begin
    tick      = (pcnt_reg >= prescale_i);
    pcnt_next = tick ? '0 : (pcnt_reg + PCNT_ONE);
  end

  // Prescaler counter register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PDATA_SIZE; gi++) begin : g_pin
      logic [CNT_SIZE-1:0] cnt_reg;
      logic [CNT_SIZE-1:0] cnt_next;
      logic                deb_reg;
      logic                deb_next;
      logic                change_reg;
      logic                change_next;
      logic                glitch_reg;
      logic                glitch_next;

      // Filter decision in priority order: bypass, settled, waiting, accept, count.
      always_comb begin
        cnt_next    = cnt_reg;
        deb_next    = deb_reg;
        change_next = 1'b0;
        glitch_next = 1'b0;
        if (bypass_i[gi]) begin
          deb_next    = sync_s[gi];
          cnt_next    = '0;
          change_next = sync_s[gi] ^ deb_reg;
        end else if (sync_s[gi] == deb_reg) begin
          cnt_next    = '0;
          glitch_next = (cnt_reg != '0);
        end else if (tick) begin
          if (cnt_reg >= threshold_i) begin
            deb_next    = sync_s[gi];
            cnt_next    = '0;
            change_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end

      // Per-pin filter state and registered event pulses.
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          cnt_reg    <= '0;
          deb_reg    <= 1'b0;
          change_reg <= 1'b0;
          glitch_reg <= 1'b0;
        end else begin
          cnt_reg    <= cnt_next;
          deb_reg    <= deb_next;
          change_reg <= change_next;
          glitch_reg <= glitch_next;
        end
      end

      assign deb_o[gi]    = deb_reg;
      assign change_o[gi] = change_reg;
      assign glitch_o[gi] = glitch_reg;
    end
  endgenerate

endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: directed scenarios plus a randomized run, every cycle
// compared against a behavioural model of the debounce rules.
module tb_gpio_debounce;

  localparam int NSTG = 2;

  logic        PCLK;
  logic        PRESETn;
  logic [15:0] prescale;
  logic [7:0]  threshold;
  logic [7:0]  bypass;
  logic [7:0]  pad;
  logic [7:0]  deb_o;
  logic [7:0]  change_o;
  logic [7:0]  glitch_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state
  logic [7:0] m_q[$];
  int         m_pcnt;
  int         m_cnt[8];
  logic [7:0] m_deb;
  logic [7:0] m_chg;
  logic [7:0] m_gl;

  gpio_debounce #(
    .PDATA_SIZE(8), .CNT_SIZE(8), .PRE_SIZE(16), .INPUT_STAGES(NSTG)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .prescale_i(prescale),
    .threshold_i(threshold), .bypass_i(bypass), .pad_i(pad),
    .deb_o(deb_o), .change_o(change_o), .glitch_o(glitch_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < NSTG; i++) m_q.push_back(8'h00);
    m_pcnt = 0;
    for (int n = 0; n < 8; n++) m_cnt[n] = 0;
    m_deb = 8'h00;
    m_chg = 8'h00;
    m_gl  = 8'h00;
  endtask

  // One clock edge of the debounce rules, using values present before the edge.
  task automatic model_update();
    logic [7:0] s;
    bit         tick;
    s    = m_q[0];
    tick = (m_pcnt >= int'(prescale));
    for (int n = 0; n < 8; n++) begin
      m_chg[n] = 1'b0;
      m_gl[n]  = 1'b0;
      if (bypass[n]) begin
        m_chg[n] = (s[n] != m_deb[n]);
        m_deb[n] = s[n];
        m_cnt[n] = 0;
      end else if (s[n] == m_deb[n]) begin
        m_gl[n]  = (m_cnt[n] != 0);
        m_cnt[n] = 0;
      end else if (tick) begin
        if (m_cnt[n] >= int'(threshold)) begin
          m_deb[n] = s[n];
          m_chg[n] = 1'b1;
          m_cnt[n] = 0;
        end else begin
          m_cnt[n] = m_cnt[n] + 1;
        end
      end
    end
    m_pcnt = tick ? 0 : m_pcnt + 1;
    void'(m_q.pop_front());
    m_q.push_back(pad);
  endtask

  task automatic compare_all();
    check_eq("deb", {24'h0, deb_o}, {24'h0, m_deb});
    check_eq("chg", {24'h0, change_o}, {24'h0, m_chg});
    check_eq("glt", {24'h0, glitch_o}, {24'h0, m_gl});
    check_eq("excl", {24'h0, change_o & glitch_o}, 32'h0);
  endtask

  // Advance one cycle and compare at the following falling edge.
  task automatic step();
    @(posedge PCLK);
    if (!PRESETn) model_reset();
    else model_update();
    @(negedge PCLK);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESETn = 1'b0;
    model_reset();
    step();
    step();
    PRESETn = 1'b1;
  endtask

  int lat;
  int cnt_a;
  int cnt_b;
  logic [7:0] hist[$];

  initial begin
    PRESETn   = 1'b0;
    prescale  = 16'd0;
    threshold = 8'd3;
    bypass    = 8'h00;
    pad       = 8'h00;
    model_reset();

    // Reset state
    do_reset();
    check_eq("rst_deb", {24'h0, deb_o}, 32'h0);
    check_eq("rst_chg", {24'h0, change_o}, 32'h0);
    check_eq("rst_glt", {24'h0, glitch_o}, 32'h0);
    $display("phase 1: reset state checked");

    // All pads rise, P=0 T=3: deb after 2+4 cycles, one change pulse
    pad = 8'hFF;
    lat = 0; cnt_a = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (deb_o == 8'hFF && lat == 0) lat = k;
      if (change_o == 8'hFF) cnt_a++;
    end
    check_eq("rise_lat", lat, 6);
    check_eq("rise_chg_cnt", cnt_a, 1);
    $display("phase 2: all-pin rise latency=%0d change pulses=%0d", lat, cnt_a);

    // Short pulse on pin0 is rejected and reported as glitch
    do_reset();
    pad = 8'h01;
    step(); step();
    pad = 8'h00;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (glitch_o[0]) cnt_a++;
      if (change_o[0] || deb_o[0]) cnt_b++;
    end
    check_eq("glitch_cnt", cnt_a, 1);
    check_eq("glitch_nochg", cnt_b, 0);
    $display("phase 3: short pulse glitches=%0d changes=%0d", cnt_a, cnt_b);

    // P=4 T=1: two ticks, 5 cycles apart, from reset phase
    prescale = 16'd4; threshold = 8'd1;
    do_reset();
    pad = 8'h08;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (deb_o[3] && lat == 0) lat = k;
    end
    check_eq("presc_lat", lat, 10);
    check_eq("presc_bound", (lat - NSTG) <= 10, 1);
    $display("phase 4: prescaled latency=%0d", lat);

    // Bypass pin0 toggled every cycle; pin1 toggled but filtered
    prescale = 16'd0; threshold = 8'd3; bypass = 8'h01;
    do_reset();
    hist = {};
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 20; k++) begin
      pad = (k % 2 == 1) ? 8'h03 : 8'h00;
      hist.push_back(pad);
      step();
      if (k >= 2) check_eq("byp_track", deb_o[0], hist[k-2][0]);
      if (glitch_o[0]) cnt_a++;
      if (deb_o[1]) cnt_b++;
    end
    check_eq("byp_noglt", cnt_a, 0);
    check_eq("byp_other", cnt_b, 0);
    bypass = 8'h00;
    $display("phase 5: bypass tracking, pin0 glitches=%0d", cnt_a);

    // Lower threshold mid-count: accepted on the next tick
    threshold = 8'd200;
    do_reset();
    pad = 8'h04;
    for (int k = 0; k < 100; k++) step();
    check_eq("thr_hold", deb_o[2], 1'b0);
    threshold = 8'd10;
    step();
    check_eq("thr_drop", deb_o[2], 1'b1);
    $display("phase 6: threshold drop applied");

    // Asynchronous reset mid-count clears outputs immediately
    threshold = 8'd2;
    do_reset();
    pad = 8'hFF;
    for (int k = 0; k < 10; k++) step();
    check_eq("pre_rst_deb", {24'h0, deb_o}, 32'hFF);
    threshold = 8'd20;
    pad = 8'h00;
    for (int k = 0; k < 5; k++) step();
    #2 PRESETn = 1'b0;
    #1;
    model_reset();
    check_eq("arst_deb", {24'h0, deb_o}, 32'h0);
    check_eq("arst_chg", {24'h0, change_o}, 32'h0);
    check_eq("arst_glt", {24'h0, glitch_o}, 32'h0);
    @(negedge PCLK);
    step();
    pad = 8'hFF;
    PRESETn = 1'b1;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (deb_o == 8'hFF && lat == 0) lat = k;
    end
    check_eq("arst_relat", lat, 23);
    $display("phase 7: async reset, relaunch latency=%0d", lat);

    // Randomized traffic against the model
    prescale = 16'd1; threshold = 8'd2; bypass = 8'h00;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) prescale = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) threshold = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 299) == 0) bypass = 8'($urandom);
      for (int n = 0; n < 8; n++) begin
        if ($urandom_range(0, 7) == 0) pad[n] = ~pad[n];
      end
      step();
    end
    $display("phase 8: randomized run done");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
